dest_router: RTL
================

Name: dest_router

Overview:
- Consumer end of the destination interface.
- Takes the ingress packet stream alongside the per-packet destination result (2-bit port select plus invalid flag).
- Holds the packet's header words until the destination arrives, then steers the whole packet to one of NUM_PORTS egress ports, or discards it.
- Sits directly downstream of the destination calculation stage, in front of the per-port egress logic.

Parameters:
- DATA_W, 16, width of a stream word.
- NUM_PORTS, 4, egress port count; port index width is 2.
- HDR_WORDS, 3, number of header words that must be buffered before a destination can arrive.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_tdata  in  DATA_W  ingress word
- in_tvalid  in  1  ingress word valid
- in_tlast  in  1  last word of packet
- in_tready  out  1  router accepts ingress word
- dest_tdata  in  2  egress port index
- dest_tvalid  in  1  destination result valid (single-cycle pulse)
- dest_tuser  in  1  destination invalid; drop packet
- out_tdata  out  DATA_W  egress word, shared by all ports
- out_tlast  out  1  egress last, shared by all ports
- out_tvalid  out  NUM_PORTS  one-hot egress valid
- out_tready  in  NUM_PORTS  per-port egress ready
- fwd_count  out  16  packets forwarded, saturating
- drop_count  out  16  packets dropped, saturating

Behaviour:
- Word storage:
  - Internal FIFO of HDR_WORDS+1 entries, each DATA_W+1 bits (data plus last).
  - Handshake: ingress word accepted when in_tvalid & in_tready. Egress word transferred when out_tvalid[sel] & out_tready[sel].
- Reset: asserted at any time, it asynchronously clears FIFO pointers and occupancy, state=IDLE, sel=0, both counters=0, in_tready=0, out_tvalid=0, out_tdata=0, out_tlast=0. A packet in flight is abandoned and not counted.
- FSM states: IDLE, HDR, WAIT_DEST, FWD, DROP.
- IDLE:
  - in_tready=1.
  - First accepted word is pushed to the FIFO and the header count starts at 1 -> HDR.
  - If that word has tlast=1 -> DROP_FLUSH behaviour (see runt packets).
- HDR:
  - in_tready=1 until HDR_WORDS words have been buffered.
  - When the HDR_WORDS-th word is accepted -> WAIT_DEST.
- WAIT_DEST:
  - in_tready=0.
  - On dest_tvalid: latch sel=dest_tdata.
  - dest_tuser=1 -> DROP; dest_tuser=0 -> FWD.
- dest_tvalid in the same cycle as the HDR_WORDS-th word is accepted is latched and acts as in WAIT_DEST (transition taken directly).
- dest_tvalid in IDLE, FWD or DROP is ignored.
- FWD:
  - out_tvalid = onehot(sel) when the FIFO is non-empty, else 0. out_tdata/out_tlast = FIFO head.
  - in_tready = FIFO not full and the tlast word of this packet not yet accepted.
  - Simultaneous push and pop is allowed, so full throughput is one word per cycle.
  - When the word with tlast=1 is popped: fwd_count+=1 -> IDLE.
- DROP:
  - FIFO is flushed (occupancy cleared on entry); out_tvalid=0.
  - in_tready=1 and words are discarded.
  - When a word with tlast=1 is accepted, or on entry if that word was already buffered: drop_count+=1 -> IDLE.
- Runt packets (tlast within the first HDR_WORDS words):
  - The packet is dropped, drop_count+=1, FIFO flushed -> IDLE the next cycle.
  - Any dest_tvalid for that packet is ignored.
- Counters saturate at 16'hFFFF.
- Latency: first egress word valid the cycle after dest_tvalid is sampled.
- Backpressure: out_tvalid, once asserted, holds word and port stable until accepted. out_tready of non-selected ports is ignored.
- The egress one-hot never has more than one bit set.

Test Plan:
- 6-word packet, dest_tvalid with tdata=2, tuser=0 one cycle after the 3rd word -> words appear on port 2 in order (out_tvalid=4'b0100), out_tlast on word 6, fwd_count=1, other ports never valid.
- Same packet with dest_tuser=1 -> no out_tvalid; all 6 words accepted and discarded; drop_count=1; next packet to port 0 forwards normally.
- 2-word runt packet (tlast on word 2) -> dropped, drop_count=1, FSM back in IDLE after 1 cycle, spurious dest_tvalid afterwards ignored.
- Forwarding to port 1 with out_tready[1] toggled 1/0 every cycle and out_tready[3]=1 -> no word loss or duplication, in_tready deasserts when the FIFO holds 4 words, out_tdata stable while stalled.
- Reset asserted mid-FWD after 2 of 5 words sent -> all outputs 0 immediately (asynchronously), counters 0; a following packet routes correctly.
- Back-to-back packets with dest_tvalid coincident with the 3rd-word handshake, with fwd_count preloaded to 16'hFFFE by running 65534 packets (or via a force in the bench) -> two packets forwarded, count ends at 16'hFFFF.

Source files
------------

// File: rtl/dest_router.sv
// Destination router: buffers a packet's header until its destination result
// arrives, then steers the packet to one egress port or discards it.
module dest_router #(
  parameter int DATA_W    = 16,
  parameter int NUM_PORTS = 4,
  parameter int HDR_WORDS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    in_tdata,
  input  logic                 in_tvalid,
  input  logic                 in_tlast,
  output logic                 in_tready,
  input  logic [1:0]           dest_tdata,
  input  logic                 dest_tvalid,
  input  logic                 dest_tuser,
  output logic [DATA_W-1:0]    out_tdata,
  output logic                 out_tlast,
  output logic [NUM_PORTS-1:0] out_tvalid,
  input  logic [NUM_PORTS-1:0] out_tready,
  output logic [15:0]          fwd_count,
  output logic [15:0]          drop_count
);

  localparam int DEPTH = HDR_WORDS + 1;
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int HW    = $clog2(HDR_WORDS + 1);

  typedef enum logic [2:0] {IDLE, HDR, WAIT_DEST, FWD, DROP} state_t;

  state_t            state, state_nxt;
  logic [DATA_W:0]   mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     occ;
  logic [HW-1:0]     hdr_cnt, hdr_nxt;
  logic [1:0]        sel;
  logic              last_seen;
  logic [15:0]       fwd_cnt, drop_cnt;

  logic              push, pop, flush, take_dest, fwd_inc, drop_inc;
  logic              in_hs, fifo_full, fifo_empty, out_active, rdy;
  logic [DATA_W:0]   head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign fifo_full  = (occ == CW'(DEPTH));
  assign fifo_empty = (occ == '0);
  assign head       = mem[rd_ptr];
  assign in_hs      = in_tvalid & in_tready;
  assign out_active = (state == FWD) & ~fifo_empty;
  assign pop        = out_active & out_tready[sel];
  assign hdr_nxt    = (state == IDLE) ? HW'(1) : hdr_cnt + HW'(1);

  always_comb begin
    rdy = 1'b0;
    case (state)
      IDLE, HDR, DROP: rdy = 1'b1;
      FWD:             rdy = ~fifo_full & ~last_seen;
      default:         rdy = 1'b0;
    endcase
  end

  // Gated by reset so ingress is refused the moment reset rises.
  assign in_tready  = rdy & ~reset;
  assign out_tvalid = out_active ? (NUM_PORTS'(1) << sel) : '0;
  assign out_tdata  = out_active ? head[DATA_W-1:0] : '0;
  assign out_tlast  = out_active & head[DATA_W];
  assign fwd_count  = fwd_cnt;
  assign drop_count = drop_cnt;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    flush     = 1'b0;
    take_dest = 1'b0;
    fwd_inc   = 1'b0;
    drop_inc  = 1'b0;
    case (state)
      IDLE, HDR: begin
        if (in_hs) begin
          if (in_tlast) begin
            // Runt: packet ended inside the header, nothing to route.
            flush     = 1'b1;
            drop_inc  = 1'b1;
            state_nxt = IDLE;
          end else begin
            push = 1'b1;
            if (hdr_nxt == HW'(HDR_WORDS)) begin
              if (dest_tvalid) begin
                take_dest = 1'b1;
                flush     = dest_tuser;
                state_nxt = dest_tuser ? DROP : FWD;
              end else begin
                state_nxt = WAIT_DEST;
              end
            end else begin
              state_nxt = HDR;
            end
          end
        end
      end
      WAIT_DEST: begin
        if (dest_tvalid) begin
          take_dest = 1'b1;
          flush     = dest_tuser;
          state_nxt = dest_tuser ? DROP : FWD;
        end
      end
      FWD: begin
        push = in_hs;
        if (pop && head[DATA_W]) begin
          fwd_inc   = 1'b1;
          state_nxt = IDLE;
        end
      end
      DROP: begin
        if (in_hs && in_tlast) begin
          drop_inc  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      occ       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      hdr_cnt   <= '0;
      sel       <= '0;
      last_seen <= 1'b0;
      fwd_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        occ    <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        case ({push, pop})
          2'b10:   occ <= occ + CW'(1);
          2'b01:   occ <= occ - CW'(1);
          default: occ <= occ;
        endcase
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      end
      if ((state == IDLE || state == HDR) && in_hs) hdr_cnt <= hdr_nxt;
      if (take_dest) sel <= dest_tdata;
      if (state != FWD)                        last_seen <= 1'b0;
      else if (in_hs && in_tlast)              last_seen <= 1'b1;
      if (fwd_inc)  fwd_cnt  <= sat_inc(fwd_cnt);
      if (drop_inc) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  // Word storage carries no reset; the output mux hides stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_tlast, in_tdata};
  end

endmodule
